// File: rtl/jtgng_joyproc.sv
// jtgng_joyproc: debounced player inputs, SOCD, coin pulses, pause toggle and game-reset sequencer.
// Autofire on button 0 is built only when JTGNG_JOYPROC_AUTOFIRE_EN is defined.
module jtgng_joyproc #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 2,
  parameter int DEB        = 4,
  parameter int COIN_LEN   = 16,
  parameter int RST_CYCLES = 256,
  parameter int AF_PERIOD  = 4
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            rst_req,
  input  logic [PLAYERS*(4+BUTTONS)-1:0]  board_joy,
  input  logic [PLAYERS-1:0]              board_start,
  input  logic [PLAYERS-1:0]              board_coin,
  input  logic                            board_pause,
  input  logic [PLAYERS-1:0]              autofire,
  output logic [PLAYERS*(4+BUTTONS)-1:0]  game_joy,
  output logic [PLAYERS-1:0]              game_start,
  output logic [PLAYERS-1:0]              game_coin,
  output logic                            game_pause,
  output logic                            game_rst
);
  localparam int JW = 4 + BUTTONS;
  localparam int NJ = PLAYERS * JW;
  localparam int CO = NJ + PLAYERS;
  localparam int N  = NJ + 2 * PLAYERS + 1;
  typedef enum logic [1:0] {RUN, REQ, TAIL} st_t;
  st_t st_q, st_d;
  logic [15:0] rc_q, rc_d;
  logic [N-1:0] raw, lvl_q, lvl_d;
  logic [3:0] dc_q [N], dc_d [N];
  logic [7:0] coin_q [PLAYERS], coin_d [PLAYERS];
  logic [NJ-1:0] game_joy_q, game_joy_d;
  logic [PLAYERS-1:0] game_start_q, game_start_d, game_coin_q, game_coin_d;
  logic game_pause_q, game_pause_d, grst_d;
  logic [JW-1:0] j;
  assign raw = {board_pause, board_coin, board_start, board_joy};
  always_comb begin
    st_d = st_q;
    rc_d = rc_q;
    case (st_q)
      RUN: if (rst_req) st_d = REQ;
      REQ: if (!rst_req) begin st_d = TAIL; rc_d = '0; end
      default:
        if (rst_req) st_d = REQ;
        else if (rc_q == 16'(RST_CYCLES - 1)) st_d = RUN;
        else rc_d = rc_q + 16'd1;
    endcase
    grst_d = st_d != RUN;
  end
  // a sample equal to the current level restarts the run of differing samples
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < N; i++) begin
      dc_d[i] = dc_q[i];
      if (tick) begin
        if (raw[i] == lvl_q[i]) dc_d[i] = '0;
        else if (dc_q[i] == 4'(DEB - 1)) begin lvl_d[i] = raw[i]; dc_d[i] = '0; end
        else dc_d[i] = dc_q[i] + 4'd1;
      end
    end
  end
`ifdef JTGNG_JOYPROC_AUTOFIRE_EN
  logic [7:0] af_q [PLAYERS], af_d [PLAYERS];
  logic [PLAYERS-1:0] afp_q, afp_d;
  always_comb begin
    afp_d = afp_q;
    for (int p = 0; p < PLAYERS; p++) begin
      af_d[p] = af_q[p];
      if (!lvl_q[p*JW+4] || !autofire[p]) begin af_d[p] = '0; afp_d[p] = 1'b0; end
      else if (tick) begin
        af_d[p]  = (af_q[p] == 8'(AF_PERIOD - 1)) ? 8'd0 : af_q[p] + 8'd1;
        afp_d[p] = afp_q[p] ^ (af_q[p] == 8'(AF_PERIOD - 1));
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      af_q  <= '{default: '0};
      afp_q <= '0;
    end else begin
      af_q  <= af_d;
      afp_q <= afp_d;
    end
`else
  logic unused_af;
  assign unused_af = ^{autofire, 8'(AF_PERIOD)};
`endif
  always_comb begin
    j = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      j = lvl_q[p*JW +: JW];
      j[1:0] = &j[1:0] ? 2'b00 : j[1:0];
      j[3:2] = &j[3:2] ? 2'b00 : j[3:2];
`ifdef JTGNG_JOYPROC_AUTOFIRE_EN
      j[4] = j[4] & ~afp_q[p];
`endif
      game_joy_d[p*JW +: JW] = grst_d ? '1 : ~j;
      coin_d[p] = grst_d ? 8'd0
                : (lvl_d[CO+p] & ~lvl_q[CO+p] & (coin_q[p] == 8'd0)) ? 8'(COIN_LEN)
                : (tick && coin_q[p] != 8'd0) ? coin_q[p] - 8'd1 : coin_q[p];
      game_coin_d[p] = grst_d | (coin_q[p] == 8'd0);
    end
    game_start_d = grst_d ? '1 : ~lvl_q[NJ +: PLAYERS];
    game_pause_d = grst_d ? 1'b0 : game_pause_q ^ (lvl_d[N-1] & ~lvl_q[N-1]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q         <= TAIL;
      rc_q         <= '0;
      lvl_q        <= '0;
      dc_q         <= '{default: '0};
      coin_q       <= '{default: '0};
      game_joy_q   <= '1;
      game_start_q <= '1;
      game_coin_q  <= '1;
      game_pause_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      rc_q         <= rc_d;
      lvl_q        <= lvl_d;
      dc_q         <= dc_d;
      coin_q       <= coin_d;
      game_joy_q   <= game_joy_d;
      game_start_q <= game_start_d;
      game_coin_q  <= game_coin_d;
      game_pause_q <= game_pause_d;
    end
  assign game_joy   = game_joy_q;
  assign game_start = game_start_q;
  assign game_coin  = game_coin_q;
  assign game_pause = game_pause_q;
  assign game_rst   = st_q != RUN;
endmodule
